// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the up/down counter checker and the counter benches.
package count_chk_pkg;

    localparam int unsigned WIDTH_DEFAULT  = 3;
    localparam int unsigned LOCK_N_DEFAULT = 2;
    localparam int unsigned ERR_W_DEFAULT  = 8;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAcq,
        StLocked
    } chk_state_e;

endpackage

// File: rtl/count_step_predict.sv
// Next-value predictor for an up/down counter step, with a flag for the max<->0 crossing.
module count_step_predict
    import count_chk_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] prev_count_i,
    input  logic             prev_mode_i,
    output logic [WIDTH-1:0] expected_o,
    output logic             cross_o
);

    localparam logic [WIDTH-1:0] One    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MaxVal = '1;

    always_comb begin
        if (prev_mode_i == MODE_DOWN) begin
            expected_o = prev_count_i - One;
            cross_o    = (prev_count_i == '0);
        end else begin
            expected_o = prev_count_i + One;
            cross_o    = (prev_count_i == MaxVal);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Passive checker for a WIDTH-bit up/down counter: locks onto a valid sequence and
// reports mismatches (err), a saturating error count, and wrap-arounds.
module count_checker
    import count_chk_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEFAULT,
    parameter int unsigned ERR_W  = ERR_W_DEFAULT,
    parameter int unsigned LOCK_N = LOCK_N_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] expected_o
);

    localparam int unsigned         GoodW      = $clog2(LOCK_N + 1);
    localparam logic [GoodW-1:0]    LockTarget = GoodW'(LOCK_N);
    localparam logic [GoodW-1:0]    GoodOne    = GoodW'(1);
    localparam logic [ERR_W-1:0]    ErrOne     = ERR_W'(1);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             prev_mode_q, prev_mode_d;
    logic [GoodW-1:0] good_cnt_q, good_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] expected_q, expected_d;

    logic [WIDTH-1:0] pred_cur;
    logic             cross_cur;
    logic             cross_next;
    logic             good;

    // Prediction for the sample arriving now, from the captured history.
    count_step_predict #(.WIDTH(WIDTH)) u_predict_cur (
        .prev_count_i (prev_count_q),
        .prev_mode_i  (prev_mode_q),
        .expected_o   (pred_cur),
        .cross_o      (cross_cur)
    );

    // Prediction for the following sample, registered so it reads 0 out of reset.
    count_step_predict #(.WIDTH(WIDTH)) u_predict_next (
        .prev_count_i (count_i),
        .prev_mode_i  (mode_i),
        .expected_o   (expected_d),
        .cross_o      (cross_next)
    );

    assign good = (count_i == pred_cur);

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_d        = 1'b0;
        wrap_d       = 1'b0;
        err_count_d  = err_count_q;
        prev_count_d = count_i;
        prev_mode_d  = mode_i;

        unique case (state_q)
            StIdle: begin
                state_d    = StAcq;
                good_cnt_d = '0;
            end
            StAcq: begin
                if (good) begin
                    good_cnt_d = good_cnt_q + GoodOne;
                    if (good_cnt_q + GoodOne == LockTarget) begin
                        state_d = StLocked;
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end
            StLocked: begin
                if (good) begin
                    wrap_d = cross_cur;
                end else begin
                    err_d      = 1'b1;
                    good_cnt_d = '0;
                    state_d    = StAcq;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ErrOne;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            prev_count_q <= '0;
            prev_mode_q  <= MODE_UP;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            err_count_q  <= '0;
            expected_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_mode_q  <= prev_mode_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            err_count_q  <= err_count_d;
            expected_q   <= expected_d;
        end
    end

    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign wrap_o      = wrap_q;
    assign err_count_o = err_count_q;
    assign expected_o  = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed plus random bench for count_checker against a value-level sequence model.
module tb_count_checker;

    localparam int Mod   = 8;
    localparam int LockN = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       mode_i = 1'b0;
    logic [2:0] count_i = 3'd0;

    logic       locked_o, err_o, wrap_o;
    logic [7:0] err_count_o;
    logic [2:0] expected_o;

    logic       locked2, err2, wrap2;
    logic [1:0] err_count2;
    logic [2:0] expected2;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: value history and a running count of trusted steps.
    bit m_hist;
    int m_prev, m_mode, m_good, m_errs, m_exp;
    bit m_locked, m_err, m_wrap;

    count_checker #(.WIDTH(3), .ERR_W(8), .LOCK_N(LockN)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mode_i      (mode_i),
        .count_i     (count_i),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .err_count_o (err_count_o),
        .wrap_o      (wrap_o),
        .expected_o  (expected_o)
    );

    count_checker #(.WIDTH(3), .ERR_W(2), .LOCK_N(LockN)) u_dut_sat (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mode_i      (mode_i),
        .count_i     (count_i),
        .locked_o    (locked2),
        .err_o       (err2),
        .err_count_o (err_count2),
        .wrap_o      (wrap2),
        .expected_o  (expected2)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 0; m_prev = 0; m_mode = 0; m_good = 0; m_errs = 0; m_exp = 0;
        m_locked = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input int c, input int md);
        int pred;
        m_err  = 0;
        m_wrap = 0;
        if (!m_hist) begin
            m_hist = 1; m_good = 0; m_locked = 0;
        end else begin
            pred = (m_mode != 0) ? (m_prev + Mod - 1) % Mod : (m_prev + 1) % Mod;
            if (m_locked) begin
                if (c == pred) begin
                    m_wrap = (m_mode == 0 && c == 0) || (m_mode != 0 && c == Mod - 1);
                end else begin
                    m_err = 1; m_errs++; m_good = 0; m_locked = 0;
                end
            end else if (c == pred) begin
                m_good++;
                if (m_good >= LockN) m_locked = 1;
            end else begin
                m_good = 0;
            end
        end
        m_prev = c;
        m_mode = md;
        m_exp  = (md != 0) ? (c + Mod - 1) % Mod : (c + 1) % Mod;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"}, locked_o, m_locked);
        check({tag, ".err"}, err_o, m_err);
        check({tag, ".wrap"}, wrap_o, m_wrap);
        check({tag, ".err_count"}, err_count_o, (m_errs > 255) ? 255 : m_errs);
        check({tag, ".expected"}, expected_o, m_exp);
        check({tag, ".err_count_sat"}, err_count2, (m_errs > 3) ? 3 : m_errs);
        check({tag, ".locked_sat"}, locked2, m_locked);
    endtask

    task automatic step(input string tag, input int c, input int md);
        @(negedge clk_i);
        count_i = 3'(c);
        mode_i  = md[0];
        @(posedge clk_i);
        model_edge(c, md);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int r, c, md;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Lock-up from reset
        step("lock0", 0, 0);
        step("lock1", 1, 0);
        step("lock2", 2, 0);
        step("up3", 3, 0);
        step("up4", 4, 0);

        // Direction change
        step("dir5", 5, 1);
        step("dir4", 4, 1);
        step("dir3", 3, 0);
        step("up4b", 4, 0);
        step("up5", 5, 0);

        // Error injection and relock
        step("errinj", 7, 0);
        step("relock0", 0, 0);
        step("relock1", 1, 0);

        // Wrap up then down
        for (int v = 2; v <= 7; v++) step("wrapup_pre", v, 0);
        step("wrapup", 0, 0);
        step("wrapdn1", 1, 1);
        step("wrapdn0", 0, 1);
        step("wrapdn7", 7, 1);
        step("wrapdn6", 6, 1);

        // Saturation of the narrow error counter
        do_reset("sat_reset");
        step("sat_l0", 0, 0);
        step("sat_l1", 1, 0);
        step("sat_l2", 2, 0);
        for (int k = 0; k < 5; k++) begin
            c = (m_exp + 3) % Mod;
            step("sat_bad", c, 0);
            step("sat_re1", (c + 1) % Mod, 0);
            step("sat_re2", (c + 2) % Mod, 0);
        end

        // Async reset while locked with err_count=2
        do_reset("ar_pre_reset");
        step("ar_l0", 3, 0);
        step("ar_l1", 4, 0);
        step("ar_l2", 5, 0);
        for (int k = 0; k < 2; k++) begin
            c = (m_exp + 2) % Mod;
            step("ar_bad", c, 0);
            step("ar_re1", (c + 1) % Mod, 0);
            step("ar_re2", (c + 2) % Mod, 0);
        end
        check("ar_setup_errs", err_count_o, 2);
        do_reset("ar_reset");
        step("ar_capture", 5, 0);
        step("ar_next", 6, 0);

        // Random traffic: mostly correct steps, some mode flips, some corruption
        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 99);
            md = (r < 20) ? 1 - m_mode : m_mode;
            c  = (r >= 88) ? $urandom_range(0, Mod - 1) : m_exp;
            step("rand", c, md);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/count_checker.md
# count_checker

Passive checker at the far end of the 3-bit up/down counter interface. It samples the counter's `count` and `mode` on every clock, predicts the next value, locks onto a valid sequence, and flags mismatches and wrap-arounds. It sits beside `counter_d` / `counter_jk` on the same `clk`/`reset`, so benches and on-board self-test can check counter output without a reference model.

## Interface
- `WIDTH`, 3: count width in bits.
- `ERR_W`, 8: width of the saturating error counter.
- `LOCK_N`, 2: consecutive correct steps required to assert lock (≥1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  1  counter direction: 0 = up (+1 mod 2^WIDTH), 1 = down (−1 mod 2^WIDTH).
- `count`  in  WIDTH  counter output under check.
- `locked`  out  1  high while the observed sequence is trusted.
- `err`  out  1  one-cycle pulse: mismatch detected while locked.
- `err_count`  out  ERR_W  saturating count of `err` pulses.
- `wrap`  out  1  one-cycle pulse: a correct locked step crossed max→0 (up) or 0→max (down).
- `expected`  out  WIDTH  predicted value for the next sample.

## Operation
- Registers: `prev_count`, `prev_mode`, `good_cnt` (counts to LOCK_N), state, all outputs.
- Prediction: `expected` = `prev_count` + 1 if `prev_mode`=0, else `prev_count` − 1, both mod 2^WIDTH. The mode sampled at edge k−1 governs the count sampled at edge k, matching the counter's one-edge response to `mode`.
- Each edge (not in reset): capture `count` → `prev_count` and `mode` → `prev_mode`, then evaluate `good` = (`count` == `expected`).
- States:
  - IDLE: no history. On the first edge, capture only, with no comparison. Go to ACQ with `good_cnt`=0.
  - ACQ: if `good`, increment `good_cnt`; on reaching LOCK_N, go to LOCKED. If not `good`, set `good_cnt` to 0 and stay in ACQ. No `err` in this state.
  - LOCKED: if `good`, stay; raise `wrap` on a crossing. If not `good`, pulse `err`, increment `err_count` (holds at 2^ERR_W−1), clear `good_cnt`, and go to ACQ.
- `locked` = (state == LOCKED), registered.
- `wrap` is never raised outside LOCKED or on a mismatching step.
- A `mode` change is legal at any edge. The step after it is predicted in the new direction, so no error results.
- Simultaneous mismatch and wrap-like value: mismatch wins; `wrap` stays 0.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `prev_count`=0, `prev_mode`=0, `good_cnt`=0, `locked`=0, `err`=0, `wrap`=0, `err_count`=0, `expected`=0. All take effect immediately, with no clock edge needed.
- Reset is released synchronously in effect: the first rising edge with `reset`=1 is the IDLE capture edge.
- Latency: `err`, `wrap` and `locked` update at the same edge that samples the offending or qualifying `count`. They are valid for the following cycle.
- Minimum lock time is LOCK_N+1 edges after reset release (3 with defaults).
- Reset asserted mid-operation discards all history and counts, including `err_count`.

## Structure
- Package `count_chk_pkg` holds:
  - the state enum (IDLE, ACQ, LOCKED);
  - `MODE_UP`=0 and `MODE_DOWN`=1;
  - defaults for WIDTH and LOCK_N, shared with the counter benches.
- One sub-module: `count_step_predict` (combinational `prev_count`, `prev_mode` → `expected`, plus a crossing flag). The top module holds the FSM, `good_cnt`, the saturating `err_count`, and the output registers.

## Test plan
- Lock-up: release reset, mode=0, count 0,1,2 on successive edges → `locked`=1 after the edge sampling 2; `err`=0 throughout.
- Direction change: locked at 4 with mode=0; set mode=1 at the edge sampling 5; next count 4 → no `err`, `locked` stays 1, `expected` shows 3.
- Error injection: locked, count 5 then 7 (mode=0) → `err` high exactly one cycle, `err_count`=1, `locked`=0. Then 0,1 → relocks.
- Wrap: locked up-counting 6,7,0 → `wrap` one cycle after the edge sampling 0. Down-counting 1,0,7 → `wrap` after sampling 7.
- Saturation: ERR_W=2, cause five locked mismatches, relocking between each → `err_count` reads 1,2,3,3,3.
- Async reset mid-lock: drop `reset` between edges while `locked`=1 and `err_count`=2 → `locked`=0 and `err_count`=0 before the next edge. Then release reset, and the first edge only captures.
